axi_lite_regfile_slave: RTL and testbench
=========================================

Name: axi_lite_regfile_slave

Overview:
- Parametrised AXI4-Lite slave backed by a DEPTH x DATA_W register array.
- Successor to the single-FSM AXI-Lite slave; read and write channels run concurrently.
- AW and W are accepted in either order or in the same cycle.
- Out-of-range accesses complete with SLVERR. A saturating error counter is exported for debug.

Parameters:
- ADDR_W, 32, AXI byte-address width.
- DATA_W, 32, data width; legal values are 32 and 64. STRB_W = DATA_W/8.
- DEPTH, 256, number of words; power of two, DEPTH*STRB_W <= 2**ADDR_W.
- RESET_VAL, 0, value loaded into every word on reset.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_W  write data
- wstrb  in  STRB_W  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- err_count  out  8  saturating count of SLVERR responses (read + write)

Behaviour:
- Reset (async assert, deasserted synchronously to aclk):
  - All outputs 0, including all readys, valids, resp, rdata and err_count.
  - All words = RESET_VAL; both FSMs return to idle.
  - Readys first go 1 on the first aclk edge after areset_n rises.
  - A reset mid-transaction abandons it silently; no response is issued.
- Addressing:
  - Word index = addr >> log2(STRB_W); low address bits are ignored (no unaligned support).
  - Index >= DEPTH is out of range.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP. All outputs registered.
  - W_IDLE: awready = wready = 1.
    - AW handshake alone -> latch awaddr -> W_GOT_AW.
    - W handshake alone -> latch wdata/wstrb -> W_GOT_W.
    - Both in the same cycle -> commit -> W_RESP.
  - W_GOT_AW: awready = 0, wready = 1. W handshake -> commit -> W_RESP.
  - W_GOT_W: wready = 0, awready = 1. AW handshake -> commit -> W_RESP.
  - Commit:
    - In range: byte lanes with wstrb[i] = 1 are written; other lanes are held. bresp = OKAY.
    - Out of range: no write, bresp = SLVERR, err_count += 1.
    - wstrb = 0 in range: no change, OKAY.
  - W_RESP: awready = wready = 0, bvalid = 1, bresp stable until bready. On handshake -> W_IDLE; readys reassert the next cycle.
  - bvalid rises one cycle after the completing handshake.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On handshake: rdata = mem[index] registered (or 0 with SLVERR if out of range; err_count += 1) -> R_DATA.
  - R_DATA: arready = 0, rvalid = 1; rdata/rresp held stable until rready. On handshake -> R_IDLE.
  - Latency: rvalid rises one cycle after the AR handshake. Back-to-back reads: one every 2 cycles with rready held high.
- Simultaneous events:
  - Write commit and AR handshake to the same word in the same cycle: the read returns the pre-write value.
  - A read and a write error in the same cycle: err_count += 2.
  - err_count saturates at 255.
- Valid/ready signalling:
  - Slave never waits for bready/rready to assert bvalid/rvalid.
  - Once asserted, bvalid and rvalid never drop without a handshake.

Decomposition:
- axi_lite_pkg: add RESP_SLVERR (2'b10) next to the existing RESP_OKAY.
- axi_lite_pkg: add wr_state_t and rd_state_t enums.
- Sub-module axi_lite_reg_mem:
  - One write port with per-byte enable.
  - One synchronous read port with read-before-write ordering.
  - Owns the reset-to-RESET_VAL loop.

Test Plan:
- Reset, then AW 0x10 and W 0xDEADBEEF (wstrb 0xF) in the same cycle, bready = 1 -> bvalid 1 cycle later, OKAY; then read 0x10 -> rvalid 1 cycle after AR, rdata 0xDEADBEEF, OKAY.
- W 0x000000AA (wstrb 0x1) issued 3 cycles before AW 0x10 -> awready low until AW arrives, then bvalid; read 0x10 returns 0xDEADBEAA.
- Read 0x400 with DEPTH = 256, DATA_W = 32 -> rresp SLVERR, rdata 0, err_count 1. Write 0x400 -> bresp SLVERR, memory unchanged, err_count 2.
- Hold bready = 0 for 5 cycles after a write -> bvalid and bresp stable, awready/wready stay 0; bready = 1 -> return to idle, readys high the next cycle.
- Write 0x20 = 0x1 committing in the same cycle as an AR to 0x20 (old value 0) -> rdata 0. A subsequent read returns 0x1.
- Assert areset_n = 0 while in W_RESP and R_DATA -> all outputs 0 immediately; after release, no stale bvalid/rvalid, and a read of 0x10 returns RESET_VAL.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite definitions for the register-file slave.
//   RESP_OKAY / RESP_SLVERR : response encodings
//   wr_state_t / rd_state_t : write- and read-channel FSM states
//   sat_add8                : 8-bit saturating add used by the error counter
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_AW,
        W_GOT_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Adds 0..3 to an 8-bit count, sticking at 255 instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, write data, valids and bready/rready
//   slave  modport : drives readys, responses and read data
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_mem.sv
// axi_lite_reg_mem: DEPTH x DATA_W word store.
//   aclk, areset_n           : clock, asynchronous active-low reset (all words -> RESET_VAL)
//   wr_en/wr_idx/wr_data/wr_strb : one write port with per-byte enables
//   rd_en/rd_idx/rd_zero     : one synchronous read port; rd_zero loads 0 instead of a word
//   rd_data                  : registered read data, held until the next rd_en
// A read and write to the same word in one cycle returns the old contents,
// because both sample the array before the non-blocking update lands.
module axi_lite_reg_mem #(
    parameter int                     DATA_W    = 32,
    parameter int                     DEPTH     = 256,
    parameter int                     IDX_W     = $clog2(DEPTH),
    parameter logic [DATA_W-1:0]      RESET_VAL = '0
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  rd_en,
    input  logic                  rd_zero,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= rd_zero ? '0 : mem[rd_idx];
            end
            if (wr_en) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite slave over a DEPTH x DATA_W register array.
//   aclk, areset_n : clock, asynchronous active-low reset
//   bus            : AXI4-Lite slave port (AW/W/B/AR/R)
//   err_count      : saturating count of SLVERR responses, reads and writes combined
// Write and read channels have independent FSMs and run concurrently.
// AW and W may arrive in either order or together; the write commits on the
// cycle the second of the two handshakes completes.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic        aclk,
    input  logic        areset_n,
    axi_lite_if.slave   bus,
    output logic [7:0]  err_count
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // Compare the full word index, not the truncated one, so high address
    // bits cannot alias back into the array.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> OFF) >= DEPTH_A;
    endfunction

    // Write channel state
    wr_state_t         wr_state_reg;
    logic              awready_reg;
    logic              wready_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic [ADDR_W-1:0] awaddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;

    // Read channel state
    rd_state_t         rd_state_reg;
    logic              arready_reg;
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;

    logic [7:0]        err_count_reg;

    // Commit decode
    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;
    logic              c_oor;
    logic              wr_en;
    logic              wr_err;
    logic              rd_oor;
    logic              rd_err;

    always_comb begin
        aw_hs  = bus.awvalid && awready_reg;
        w_hs   = bus.wvalid && wready_reg;
        ar_hs  = bus.arvalid && arready_reg;

        commit = 1'b0;
        case (wr_state_reg)
            W_IDLE:   commit = aw_hs && w_hs;
            W_GOT_AW: commit = w_hs;
            W_GOT_W:  commit = aw_hs;
            default:  commit = 1'b0;
        endcase

        // Whichever half arrived earlier comes from the latch, the other live.
        c_addr = (wr_state_reg == W_GOT_AW) ? awaddr_reg : bus.awaddr;
        c_data = (wr_state_reg == W_GOT_W)  ? wdata_reg  : bus.wdata;
        c_strb = (wr_state_reg == W_GOT_W)  ? wstrb_reg  : bus.wstrb;
        c_oor  = out_of_range(c_addr);

        wr_en  = commit && !c_oor;
        wr_err = commit && c_oor;
        rd_oor = out_of_range(bus.araddr);
        rd_err = ar_hs && rd_oor;
    end

    axi_lite_reg_mem #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_mem (
        .aclk     (aclk),
        .areset_n (areset_n),
        .wr_en    (wr_en),
        .wr_idx   (c_addr[OFF +: IDX_W]),
        .wr_data  (c_data),
        .wr_strb  (c_strb),
        .rd_en    (ar_hs),
        .rd_zero  (rd_oor),
        .rd_idx   (bus.araddr[OFF +: IDX_W]),
        .rd_data  (bus.rdata)
    );

    // Write FSM. Readys stay 0 through reset and come up on the first edge
    // spent in W_IDLE.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_state_reg <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
        end else begin
            case (wr_state_reg)
                W_IDLE, W_GOT_AW, W_GOT_W: begin
                    if (commit) begin
                        wr_state_reg <= W_RESP;
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b0;
                        bvalid_reg   <= 1'b1;
                        bresp_reg    <= c_oor ? RESP_SLVERR : RESP_OKAY;
                    end else if (wr_state_reg == W_IDLE && aw_hs) begin
                        wr_state_reg <= W_GOT_AW;
                        awaddr_reg   <= bus.awaddr;
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b1;
                    end else if (wr_state_reg == W_IDLE && w_hs) begin
                        wr_state_reg <= W_GOT_W;
                        wdata_reg    <= bus.wdata;
                        wstrb_reg    <= bus.wstrb;
                        awready_reg  <= 1'b1;
                        wready_reg   <= 1'b0;
                    end else if (wr_state_reg == W_IDLE) begin
                        awready_reg  <= 1'b1;
                        wready_reg   <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wr_state_reg <= W_IDLE;
                        bvalid_reg   <= 1'b0;
                        awready_reg  <= 1'b1;
                        wready_reg   <= 1'b1;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    // Read FSM. rdata lives in the memory's read register, which only loads
    // on an AR handshake, so it is stable for the whole R_DATA phase.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_state_reg <= R_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state_reg <= R_DATA;
                        arready_reg  <= 1'b0;
                        rvalid_reg   <= 1'b1;
                        rresp_reg    <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_reg  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rd_state_reg <= R_IDLE;
                        rvalid_reg   <= 1'b0;
                        arready_reg  <= 1'b1;
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            err_count_reg <= '0;
        end else begin
            err_count_reg <= sat_add8(err_count_reg, {1'b0, wr_err} + {1'b0, rd_err});
        end
    end

    assign bus.awready = awready_reg;
    assign bus.wready  = wready_reg;
    assign bus.bvalid  = bvalid_reg;
    assign bus.bresp   = bresp_reg;
    assign bus.arready = arready_reg;
    assign bus.rvalid  = rvalid_reg;
    assign bus.rresp   = rresp_reg;
    assign err_count   = err_count_reg;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb_axi_lite_regfile_slave: directed, table-driven bench for axi_lite_regfile_slave
// (ADDR_W=32, DATA_W=32, DEPTH=256, RESET_VAL=0). Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_lite_regfile_slave;
    import axi_lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic       aclk     = 1'b0;
    logic       areset_n = 1'b1;
    logic [7:0] err_count;

    always #5 aclk = ~aclk;

    axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_lite_regfile_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .RESET_VAL (32'h0)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .bus       (bus),
        .err_count (err_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    // Write with AW issued aw_dly cycles and W issued w_dly cycles after start;
    // bready is withheld for b_dly cycles once bvalid is seen.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit   aw_done = 0;
        bit   w_done  = 0;
        bit   aw_f;
        bit   w_f;
        int   c = 0;
        logic [1:0] held;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.bready = 1'b1;
        while (!(aw_done && w_done) && c < 50) begin
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge aclk);
            if (aw_f) aw_done = 1;
            if (w_f)  w_done  = 1;
            if (w_done && !aw_done) begin
                check("got_w_wready_low", bus.wready, 1'b0);
                check("got_w_awready_high", bus.awready, 1'b1);
                check("got_w_no_bvalid", bus.bvalid, 1'b0);
            end
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) timeout_fail("wr_handshake");
        check("bvalid_latency", bus.bvalid, 1'b1);
        resp = bus.bresp;
        held = bus.bresp;
        bus.bready = (b_dly == 0);
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            check("stall_bvalid", bus.bvalid, 1'b1);
            check("stall_bresp", bus.bresp, held);
            check("stall_readys", {bus.awready, bus.wready}, 2'b00);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        check("bvalid_drop", bus.bvalid, 1'b0);
        check("wr_readys_back", {bus.awready, bus.wready}, 2'b11);
        $display("WR addr=%08h data=%08h strb=%h bresp=%0d err_count=%0d", a, d, s, resp, err_count);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit f;
        bit done = 0;
        int c = 0;
        bus.araddr = a;
        bus.rready = 1'b1;
        bus.arvalid = 1'b1;
        while (!done && c < 50) begin
            f = bus.arvalid && bus.arready;
            @(negedge aclk);
            if (f) done = 1;
            c++;
        end
        bus.arvalid = 1'b0;
        if (!done) timeout_fail("rd_handshake");
        check("rvalid_latency", bus.rvalid, 1'b1);
        d    = bus.rdata;
        resp = bus.rresp;
        @(negedge aclk);
        check("rvalid_drop", bus.rvalid, 1'b0);
        check("arready_back", bus.arready, 1'b1);
        $display("RD addr=%08h rdata=%08h rresp=%0d err_count=%0d", a, d, resp, err_count);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic [7:0]  err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0,         8'd0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 8'd0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 8'd0};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, RESP_OKAY,   32'h0,         8'd0};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'h0000_CD00, 4'h2, RESP_OKAY,   32'h0,         8'd0};
        vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, RESP_OKAY,   32'h1234_CD78, 8'd0};
        vecs[6]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   32'h0,         8'd0};
        vecs[7]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, RESP_OKAY,   32'h1234_CD78, 8'd0};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hAAAA_5555, 4'hC, RESP_OKAY,   32'h0,         8'd0};
        vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, RESP_OKAY,   32'hAAAA_0000, 8'd0};
        vecs[10] = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         8'd1};
        vecs[11] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0,         8'd2};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h0,         8'd2};
        vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, RESP_OKAY,   32'hAAAA_0000, 8'd2};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, RESP_SLVERR, 32'h0,         8'd3};

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

        // Reset
        #1 areset_n = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_readys_valids", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
        check("rst_resps", {bus.bresp, bus.rresp}, 4'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_err_count", err_count, 8'd0);
        areset_n = 1'b1;
        #1 check("rst_release_readys_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge aclk);
        check("rst_first_edge_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Table-driven vectors: AW and W together, bready/rready held high
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rs);
                check($sformatf("v%0d_bresp", i), rs, vecs[i].resp);
            end else begin
                do_read(vecs[i].addr, rd, rs);
                check($sformatf("v%0d_rresp", i), rs, vecs[i].resp);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].rdat);
            end
            check($sformatf("v%0d_err_count", i), err_count, vecs[i].err);
        end

        // W three cycles ahead of AW, single-lane strobe
        do_write(32'h10, 32'h0000_00AA, 4'h1, 3, 0, 0, rs);
        check("w_first_bresp", rs, RESP_OKAY);
        do_read(32'h10, rd, rs);
        check("w_first_rdata", rd, 32'hDEAD_BEAA);

        // AW one cycle ahead of W
        do_write(32'h1C, 32'h0BAD_F00D, 4'hF, 0, 1, 0, rs);
        do_read(32'h1C, rd, rs);
        check("aw_first_rdata", rd, 32'h0BAD_F00D);

        // bready withheld for 5 cycles
        do_write(32'h18, 32'h0000_0077, 4'hF, 0, 0, 5, rs);
        check("stall_final_bresp", rs, RESP_OKAY);
        do_read(32'h18, rd, rs);
        check("stall_rdata", rd, 32'h0000_0077);

        // Write commit and AR to the same word on the same edge
        @(negedge aclk);
        bus.awaddr = 32'h20; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
        bus.araddr = 32'h20; bus.arvalid = 1; bus.rready = 1;
        check("simul_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("simul_valids", {bus.bvalid, bus.rvalid}, 2'b11);
        check("simul_rdata_old", bus.rdata, 32'h0);
        check("simul_resps", {bus.bresp, bus.rresp}, {RESP_OKAY, RESP_OKAY});
        $display("WR+RD addr=00000020 rdata=%08h", bus.rdata);
        @(negedge aclk);
        check("simul_valids_drop", {bus.bvalid, bus.rvalid}, 2'b00);
        do_read(32'h20, rd, rs);
        check("simul_rdata_new", rd, 32'h1);

        // Read and write errors on the same edge: counter steps by two
        @(negedge aclk);
        bus.awaddr = 32'h400; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
        bus.araddr = 32'h800; bus.arvalid = 1; bus.rready = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("dual_err_resps", {bus.bresp, bus.rresp}, {RESP_SLVERR, RESP_SLVERR});
        check("dual_err_rdata", bus.rdata, 32'h0);
        check("dual_err_count", err_count, 8'd5);
        $display("WR 400 + RD 800 err_count=%0d", err_count);
        @(negedge aclk);

        // Saturation: 252 more read errors from 5 must stick at 255
        for (int i = 0; i < 252; i++) begin
            do_read(32'h400, rd, rs);
        end
        check("err_saturate", err_count, 8'd255);

        // Reset while both channels hold a pending response
        @(negedge aclk);
        bus.awaddr = 32'h10; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
        bus.araddr = 32'h10; bus.arvalid = 1; bus.rready = 0;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
        #2 areset_n = 1'b0;
        #1;
        check("midrst_ctl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
        check("midrst_resps", {bus.bresp, bus.rresp}, 4'b0);
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_err_count", err_count, 8'd0);
        bus.bready = 1; bus.rready = 1;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        #1 check("midrst_release_readys_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge aclk);
        check("midrst_readys_back", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("midrst_no_stale", {bus.bvalid, bus.rvalid}, 2'b00);
        do_read(32'h10, rd, rs);
        check("midrst_rdata_resetval", rd, 32'h0);
        check("midrst_rresp", rs, RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
